// File: rtl/jtsdram_bank_rw.sv
// jtsdram_bank_rw: SDRAM bank exerciser. It writes an address-derived pattern over
// addresses 0..last_addr of one bank port, then reads the range back and compares it.
// It counts mismatches in a saturating counter and sets a sticky flag on any mismatch.
// Optional feature: define JTSDRAM_ERRLOG_EN to add err_addr/err_data. These outputs
// hold the address and read data of the first mismatch since start.
module jtsdram_bank_rw #(
  parameter int unsigned AW   = 22,
  parameter int unsigned DW   = 16,
  parameter logic [31:0] SEED = 32'h0000_5A3C,
  parameter int unsigned EW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] last_addr,
  input  logic          slow,
  input  logic          lvbl,
  output logic [AW-1:0] ba_addr,
  output logic          ba_rd,
  output logic          ba_wr,
  output logic [DW-1:0] ba_din,
  input  logic          ba_ack,
  input  logic          ba_rdy,
  input  logic [DW-1:0] ba_dout,
  output logic          busy,
  output logic          done,
  output logic          bad,
  output logic [EW-1:0] err_cnt
`ifdef JTSDRAM_ERRLOG_EN
  ,
  output logic [AW-1:0] err_addr,
  output logic [DW-1:0] err_data
`endif
);

  localparam int unsigned PW = 4;
  localparam logic [DW-1:0] SEED_W = DW'(SEED);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_PACE = 3'd1,
    WR_REQ  = 3'd2,
    WR_WAIT = 3'd3,
    RD_PACE = 3'd4,
    RD_REQ  = 3'd5,
    RD_WAIT = 3'd6
  } state_t;

  // Test pattern, identical for the write and verify passes
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return DW'(a) ^ SEED_W;
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] lim_q, lim_d;
  logic          wronly_q, wronly_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] din_q, din_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bad_q, bad_d;
  logic [EW-1:0] err_q, err_d;
  logic [PW-1:0] pause_q, pause_d;
  logic [PW-1:0] lfsr_q, lfsr_d;

  logic start_c;
  logic gate_c;
  logic last_c;
  logic mismatch_c;
  logic wr_done_c;
  logic rd_done_c;

  // Qualified start, pacing gate and access-completion decodes
  assign start_c    = (state_q == IDLE) && start;
  assign gate_c     = slow ? (pause_q == '0) : lvbl;
  assign last_c     = (addr_q == lim_q);
  assign mismatch_c = (ba_dout != pat(addr_q));
  assign wr_done_c  = ((state_q == WR_REQ) && ba_ack && ba_rdy) ||
                      ((state_q == WR_WAIT) && ba_rdy);
  assign rd_done_c  = ((state_q == RD_REQ) && ba_ack && ba_rdy) ||
                      ((state_q == RD_WAIT) && ba_rdy);

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    lim_d    = lim_q;
    wronly_d = wronly_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    din_d    = din_q;
    busy_d   = busy_q;
    done_d   = done_q;
    bad_d    = bad_q;
    err_d    = err_q;
    pause_d  = (pause_q != '0) ? (pause_q - PW'(1)) : pause_q;
    lfsr_d   = {lfsr_q[PW-2:0], lfsr_q[PW-1] ^ lfsr_q[PW-2]};

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = '0;
          lim_d    = last_addr;
          wronly_d = (mode == 2'd1);
          done_d   = 1'b0;
          bad_d    = 1'b0;
          err_d    = '0;
          busy_d   = 1'b1;
          pause_d  = '0;
          state_d  = (mode == 2'd0) ? RD_PACE : WR_PACE;
        end
      end
      WR_PACE: begin
        if (gate_c) begin
          wr_d    = 1'b1;
          din_d   = pat(addr_q);
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (ba_ack) begin
          wr_d    = 1'b0;
          state_d = WR_WAIT;
        end
      end
      RD_PACE: begin
        if (gate_c) begin
          rd_d    = 1'b1;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (ba_ack) begin
          rd_d    = 1'b0;
          state_d = RD_WAIT;
        end
      end
      WR_WAIT, RD_WAIT: begin
      end
      default: state_d = IDLE;
    endcase

    // Write completion: advance, switch to verify, or finish a write-only run
    if (wr_done_c) begin
      pause_d = lfsr_q;
      if (!last_c) begin
        addr_d  = addr_q + AW'(1);
        state_d = WR_PACE;
      end else if (wronly_q) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        addr_d  = '0;
        state_d = RD_PACE;
      end
    end

    // Read completion: score the data, then advance or finish
    if (rd_done_c) begin
      pause_d = lfsr_q;
      if (mismatch_c) begin
        bad_d = 1'b1;
        if (err_q != '1) begin
          err_d = err_q + EW'(1);
        end
      end
      if (!last_c) begin
        addr_d  = addr_q + AW'(1);
        state_d = RD_PACE;
      end else begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      lim_q    <= '0;
      wronly_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      din_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bad_q    <= 1'b0;
      err_q    <= '0;
      pause_q  <= '0;
      lfsr_q   <= PW'(1);
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      lim_q    <= lim_d;
      wronly_q <= wronly_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      din_q    <= din_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bad_q    <= bad_d;
      err_q    <= err_d;
      pause_q  <= pause_d;
      lfsr_q   <= lfsr_d;
    end
  end

  assign ba_addr = addr_q;
  assign ba_rd   = rd_q;
  assign ba_wr   = wr_q;
  assign ba_din  = din_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bad     = bad_q;
  assign err_cnt = err_q;

`ifdef JTSDRAM_ERRLOG_EN
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic [DW-1:0] err_data_q, err_data_d;

  // Capture address and data of the first mismatch since start
  always_comb begin
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    if (start_c) begin
      err_addr_d = '0;
      err_data_d = '0;
    end else if (rd_done_c && mismatch_c && !bad_q) begin
      err_addr_d = addr_q;
      err_data_d = ba_dout;
    end
  end

  // First-mismatch log registers
  always_ff @(posedge clk) begin
    if (rst) begin
      err_addr_q <= '0;
      err_data_q <= '0;
    end else begin
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
    end
  end

  assign err_addr = err_addr_q;
  assign err_data = err_data_q;
`else
  logic unused_start_c;
  assign unused_start_c = start_c;
`endif

endmodule

// File: tb/tb_jtsdram_bank_rw.sv
// tb_jtsdram_bank_rw: randomized bench for jtsdram_bank_rw with a bank-port controller
// model, scoreboard queues of expected accesses and a run-result monitor.
// Define JTSDRAM_ERRLOG_EN to also check the first-mismatch log.
module tb_jtsdram_bank_rw;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 16;
  localparam int unsigned EW = 8;
  localparam logic [15:0] SEED = 16'h5A3C;

  logic          clk = 1'b0;
  logic          rst, start, slow, lvbl;
  logic [1:0]    mode;
  logic [AW-1:0] last_addr, ba_addr;
  logic          ba_rd, ba_wr, ba_ack, ba_rdy;
  logic [DW-1:0] ba_din, ba_dout;
  logic          busy, done, bad;
  logic [EW-1:0] err_cnt;
`ifdef JTSDRAM_ERRLOG_EN
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_data;
`endif

  jtsdram_bank_rw #(.AW(AW), .DW(DW), .SEED(32'(SEED)), .EW(EW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .last_addr(last_addr),
    .slow(slow), .lvbl(lvbl), .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr),
    .ba_din(ba_din), .ba_ack(ba_ack), .ba_rdy(ba_rdy), .ba_dout(ba_dout),
    .busy(busy), .done(done), .bad(bad), .err_cnt(err_cnt)
`ifdef JTSDRAM_ERRLOG_EN
    , .err_addr(err_addr), .err_data(err_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          errs;
    int          first_a;
    logic [15:0] first_d;
  } res_t;

  int          total = 0;
  int          nfail = 0;
  logic [15:0] mem     [512];
  logic [15:0] corrupt [512];
  int          wr_a_q[$];
  logic [15:0] wr_d_q[$];
  int          rd_a_q[$];
  res_t        res_q[$];
  int          ctl_st = 0;
  bit          ctl_wr = 1'b0;
  int          rdy_fix = -1;
  bit          lvbl_rand = 1'b0;

  function automatic logic [15:0] pat(input int a);
    return 16'(a) ^ SEED;
  endfunction

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Bank-port controller model: random ack/rdy latency, optional read corruption
  initial begin : ctl
    int          cnt;
    int          d;
    int          ca;
    logic [15:0] cd;
    cnt = 0; ca = 0; cd = '0;
    ba_ack = 1'b0; ba_rdy = 1'b0; ba_dout = '0;
    forever begin
      cyc();
      ba_ack  = 1'b0;
      ba_rdy  = 1'b0;
      ba_dout = 16'($urandom);
      if (rst) begin
        ctl_st = 0;
      end else begin
        if (ctl_st == 0) begin
          if (ba_wr || ba_rd) begin
            ctl_wr = ba_wr;
            ca     = int'(ba_addr);
            cd     = ba_din;
            cnt    = $urandom_range(0, 2);
            ctl_st = 1;
          end else if ($urandom_range(0, 7) == 0) begin
            ba_rdy = 1'b1;
          end
        end
        if (ctl_st == 1) begin
          check("req_held", 32'({ba_wr, ba_rd, ba_addr}), 32'({ctl_wr, !ctl_wr, AW'(ca)}));
          if (cnt > 0) begin
            cnt--;
          end else begin
            ba_ack = 1'b1;
            if (ctl_wr) begin
              check("wr_expected", 32'(wr_a_q.size() > 0), 1);
              if (wr_a_q.size() > 0) begin
                check("wr_addr", 32'(ca), 32'(wr_a_q.pop_front()));
                check("wr_data", 32'(cd), 32'(wr_d_q.pop_front()));
              end
            end else begin
              check("rd_expected", 32'(rd_a_q.size() > 0), 1);
              if (rd_a_q.size() > 0) begin
                check("rd_addr", 32'(ca), 32'(rd_a_q.pop_front()));
              end
            end
            d = (rdy_fix >= 0) ? rdy_fix : int'($urandom_range(0, 3));
            if (d == 0) begin
              ba_rdy = 1'b1;
              if (ctl_wr) mem[ca] = cd;
              else        ba_dout = mem[ca] ^ corrupt[ca];
              ctl_st = 0;
            end else begin
              cnt    = d - 1;
              ctl_st = 2;
            end
          end
        end else if (ctl_st == 2) begin
          if (cnt > 0) begin
            cnt--;
          end else begin
            ba_rdy = 1'b1;
            if (ctl_wr) mem[ca] = cd;
            else        ba_dout = mem[ca] ^ corrupt[ca];
            ctl_st = 0;
          end
        end
      end
    end
  end

  // Monitor: on each rising done, pop the expected run result and compare
  initial begin : mon
    logic dprev;
    res_t r;
    int   exp_e;
    dprev = 1'b0;
    forever begin
      cyc();
      if (!rst && done && !dprev) begin
        check("res_pending", 32'(res_q.size() > 0), 1);
        if (res_q.size() > 0) begin
          r     = res_q.pop_front();
          exp_e = (r.errs > 255) ? 255 : r.errs;
          check("busy_at_done", 32'(busy), 0);
          check("bad_flag", 32'(bad), 32'(r.errs > 0));
          check("err_cnt", 32'(err_cnt), 32'(exp_e));
          check("wr_left", 32'(wr_a_q.size()), 0);
          check("rd_left", 32'(rd_a_q.size()), 0);
`ifdef JTSDRAM_ERRLOG_EN
          check("err_addr", 32'(err_addr), 32'(r.first_a));
          check("err_data", 32'(err_data), 32'(r.first_d));
`endif
        end
      end
      dprev = done;
    end
  end

  // Random vertical-blank activity for the randomized runs
  initial begin : lvgen
    forever begin
      cyc();
      if (lvbl_rand) lvbl = ($urandom_range(0, 3) != 0);
    end
  end

  // Compute the expected accesses and result of a run, then pulse start
  task automatic issue(input int m, input int last, input bit slw);
    res_t        r;
    logic [15:0] v;
    r.errs = 0; r.first_a = 0; r.first_d = '0;
    if (m != 1) begin
      for (int a = 0; a <= last; a++) begin
        rd_a_q.push_back(a);
        v = ((m == 0) ? mem[a] : pat(a)) ^ corrupt[a];
        if (v != pat(a)) begin
          if (r.errs == 0) begin
            r.first_a = a;
            r.first_d = v;
          end
          r.errs++;
        end
      end
    end
    if (m != 0) begin
      for (int a = 0; a <= last; a++) begin
        wr_a_q.push_back(a);
        wr_d_q.push_back(pat(a));
      end
    end
    res_q.push_back(r);
    slow      = slw;
    mode      = 2'(m);
    last_addr = AW'(last);
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    wr_a_q.delete();
    wr_d_q.delete();
    rd_a_q.delete();
    res_q.delete();
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (done) break;
      cyc();
    end
    check("run_done", 32'(done), 1);
    if (!done) reset_dut();
    cyc();
    cyc();
  endtask

  task automatic run(input int m, input int last, input bit slw, input bit dbl);
    issue(m, last, slw);
    if (dbl) begin
      repeat (3) cyc();
      mode      = 2'd1;
      last_addr = '0;
      start     = 1'b1;
      cyc();
      start     = 1'b0;
    end
    wait_done((last + 1) * 2 * 40 + 200);
  endtask

  initial begin : main
    bit seen;
    rst = 1'b1; start = 1'b0; mode = '0; last_addr = '0; slow = 1'b0; lvbl = 1'b1;
    for (int a = 0; a < 512; a++) begin
      mem[a]     = 16'($urandom);
      corrupt[a] = '0;
    end
    repeat (3) cyc();
    check("rst_addr", 32'(ba_addr), 0);
    check("rst_rd", 32'(ba_rd), 0);
    check("rst_wr", 32'(ba_wr), 0);
    check("rst_din", 32'(ba_din), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_bad", 32'(bad), 0);
    check("rst_err", 32'(err_cnt), 0);
    rst = 1'b0;
    cyc();

    run(2, 15, 1'b0, 1'b0);
    corrupt[5] = 16'h0100;
    run(2, 15, 1'b0, 1'b0);
    corrupt[5] = '0;
    run(1, 3, 1'b0, 1'b0);
    run(0, 15, 1'b0, 1'b0);
    run(2, 0, 1'b0, 1'b0);

    // Requests must wait for vertical blank when not in slow mode
    lvbl = 1'b0;
    issue(2, 7, 1'b0);
    seen = 1'b0;
    repeat (100) begin
      cyc();
      if (ba_wr || ba_rd) seen = 1'b1;
    end
    check("lvbl_low_no_req", 32'(seen), 0);
    check("lvbl_low_busy", 32'(busy), 1);
    lvbl = 1'b1;
    wait_done(2000);

    run(2, 10, 1'b0, 1'b1);
    run(3, 20, 1'b1, 1'b0);
    run(3, 511, 1'b0, 1'b0);

    // Every read wrong: counter must saturate
    for (int a = 0; a < 300; a++) begin
      mem[a]     = pat(a);
      corrupt[a] = 16'h0001;
    end
    run(0, 299, 1'b0, 1'b0);
    for (int a = 0; a < 300; a++) corrupt[a] = '0;

    // Reset while a write is outstanding at the controller
    rdy_fix = 3;
    issue(2, 15, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      cyc();
      if (ctl_st == 2 && ctl_wr && !ba_wr && busy) begin
        seen = 1'b1;
        break;
      end
    end
    check("mid_wr_wait_reached", 32'(seen), 1);
    rst = 1'b1;
    cyc();
    check("midrst_busy", 32'(busy), 0);
    check("midrst_wr", 32'(ba_wr), 0);
    check("midrst_rd", 32'(ba_rd), 0);
    check("midrst_err", 32'(err_cnt), 0);
    cyc();
    rst = 1'b0;
    wr_a_q.delete();
    wr_d_q.delete();
    rd_a_q.delete();
    res_q.delete();
    rdy_fix = -1;
    cyc();
    run(2, 15, 1'b0, 1'b0);

    // Randomized runs
    lvbl_rand = 1'b1;
    for (int t = 0; t < 10; t++) begin
      int m;
      int last;
      m    = $urandom_range(0, 3);
      last = $urandom_range(0, 40);
      for (int k = 0; k < 3; k++) corrupt[$urandom_range(0, 40)] = 16'($urandom_range(1, 65535));
      run(m, last, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int a = 0; a <= 40; a++) corrupt[a] = '0;
    end
    lvbl_rand = 1'b0;
    lvbl      = 1'b1;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, nfail);
    $finish;
  end

endmodule
